// File: rtl/apb_slave_regbank.sv
// APB slave register bank: zero-wait-state two-phase transfers, protocol checking,
// and saturating read/write access counters.
module apb_slave_regbank #(
    parameter int SEL_INDEX = 0,
    parameter int ADDR_W    = 4,
    parameter int COUNT_W   = 16
) (
    input  logic               Hclk,
    input  logic               Hresetn,
    input  logic [2:0]         Pselx,
    input  logic               Penable,
    input  logic               Pwrite,
    input  logic [31:0]        Paddr,
    input  logic [31:0]        Pwdata,
    output logic [31:0]        Prdata,
    output logic [COUNT_W-1:0] wr_count,
    output logic [COUNT_W-1:0] rd_count,
    output logic               prot_err
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                  r_state;
    logic [ADDR_W-1:0]       r_addr_idx;
    logic                    r_write;
    logic [DATA_W-1:0]       r_mem [DEPTH];

    logic                    w_sel;
    logic [ADDR_W-1:0]       w_idx;
    logic                    w_to_setup;
    logic                    w_enable;
    logic                    w_match;
    logic                    w_xfer_ok;
    logic                    w_rd_capture;
    logic                    w_err_set;
    logic                    w_unused;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_sel        = Pselx[SEL_INDEX];
    assign w_idx        = Paddr[ADDR_W+1:2];
    // A setup phase from any state lands in SETUP, so capture is state-independent.
    assign w_to_setup   = w_sel & ~Penable;
    assign w_enable     = (r_state == ST_SETUP) & w_sel & Penable;
    assign w_match      = (w_idx == r_addr_idx) && (Pwrite == r_write);
    assign w_xfer_ok    = w_enable & w_match;
    assign w_rd_capture = w_sel & ~Penable & ~Pwrite;

    always_comb begin
        w_err_set = 1'b0;
        case (r_state)
            ST_IDLE:   w_err_set = w_sel & Penable;
            ST_SETUP:  w_err_set = ~w_sel | (w_enable & ~w_match);
            ST_ACCESS: w_err_set = w_sel & Penable;
            default:   w_err_set = 1'b0;
        endcase
    end

    // Address bits outside the word index and the other select lines are intentionally ignored.
    assign w_unused = &{1'b0, Paddr[31:ADDR_W+2], Paddr[1:0], Pselx};

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   r_state <= w_to_setup ? ST_SETUP : ST_IDLE;
                ST_SETUP:  begin
                    if (!w_sel)       r_state <= ST_IDLE;
                    else if (Penable) r_state <= ST_ACCESS;
                    else              r_state <= ST_SETUP;
                end
                ST_ACCESS: r_state <= w_to_setup ? ST_SETUP : ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_addr_idx <= '0;
            r_write    <= 1'b0;
        end else if (w_to_setup) begin
            r_addr_idx <= w_idx;
            r_write    <= Pwrite;
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_xfer_ok && r_write) begin
            r_mem[r_addr_idx] <= Pwdata;
        end
    end

    // Read data is fetched at the end of setup so it is stable for the whole enable cycle.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            Prdata <= '0;
        end else if (w_rd_capture) begin
            Prdata <= r_mem[w_idx];
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            wr_count <= '0;
            rd_count <= '0;
        end else if (w_xfer_ok) begin
            if (r_write) wr_count <= sat_inc(wr_count);
            else         rd_count <= sat_inc(rd_count);
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            prot_err <= 1'b0;
        end else if (w_err_set) begin
            prot_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank: a per-cycle vector table plus hand-written
// sequences for protocol errors and reset during a transfer.
module tb_apb_slave_regbank;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;

    logic [31:0] prdata_a, prdata_b;
    logic [15:0] wr_a, rd_a;
    logic [1:0]  wr_b, rd_b;
    logic        err_a, err_b;

    int n_checks = 0;
    int n_err    = 0;

    always #5 Hclk = ~Hclk;

    apb_slave_regbank #(.SEL_INDEX(0), .ADDR_W(4), .COUNT_W(16)) dut_a (
        .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable),
        .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata_a),
        .wr_count(wr_a), .rd_count(rd_a), .prot_err(err_a)
    );

    apb_slave_regbank #(.SEL_INDEX(0), .ADDR_W(4), .COUNT_W(2)) dut_b (
        .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable),
        .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata_b),
        .wr_count(wr_b), .rd_count(rd_b), .prot_err(err_b)
    );

    typedef struct {
        logic [2:0]  psel;
        logic        en;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          wa;
        int          ra;
        int          wb;
        int          rb;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [2:0] psel, input logic en, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] prdata, input int wa, input int ra,
                       input int wb, input int rb, input logic err);
        vec_t v;
        v.psel = psel; v.en = en; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.prdata = prdata; v.wa = wa; v.ra = ra; v.wb = wb; v.rb = rb; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [2:0] psel, input logic en, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
        Pselx = psel; Penable = en; Pwrite = wr; Paddr = addr; Pwdata = wdata;
    endtask

    // One bus cycle: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic [2:0] psel, input logic en, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge Hclk);
        apply(psel, en, wr, addr, wdata);
        @(posedge Hclk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge Hclk);
        apply(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        Hresetn = 1'b0;
        @(negedge Hclk);
        Hresetn = 1'b1;
    endtask

    initial begin
        Hresetn = 1'b0;
        apply(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge Hclk);
        #1;
        check("reset prdata", prdata_a, 32'h0);
        check("reset wr_count", 32'(wr_a), 32'h0);
        check("reset rd_count", 32'(rd_a), 32'h0);
        check("reset prot_err", 32'(err_a), 32'h0);
        @(negedge Hclk);
        Hresetn = 1'b1;

        //   psel    en   wr   addr    wdata          prdata         wa ra wb rb err
        add(3'b000, 1'b0, 1'b0, 32'h00, 32'h0,        32'h0,         0, 0, 0, 0, 1'b0);
        add(3'b001, 1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 32'h0,         0, 0, 0, 0, 1'b0);
        add(3'b001, 1'b1, 1'b1, 32'h08, 32'hDEADBEEF, 32'h0,         1, 0, 1, 0, 1'b0);
        add(3'b001, 1'b0, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF,  1, 0, 1, 0, 1'b0);
        add(3'b001, 1'b1, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF,  1, 1, 1, 1, 1'b0);
        add(3'b000, 1'b0, 1'b0, 32'h00, 32'h0,        32'hDEADBEEF,  1, 1, 1, 1, 1'b0);
        add(3'b001, 1'b0, 1'b1, 32'h00, 32'h11,       32'hDEADBEEF,  1, 1, 1, 1, 1'b0);
        add(3'b001, 1'b1, 1'b1, 32'h00, 32'h11,       32'hDEADBEEF,  2, 1, 2, 1, 1'b0);
        add(3'b001, 1'b0, 1'b0, 32'h00, 32'h0,        32'h11,        2, 1, 2, 1, 1'b0);
        add(3'b001, 1'b1, 1'b0, 32'h00, 32'h0,        32'h11,        2, 2, 2, 2, 1'b0);
        add(3'b001, 1'b0, 1'b0, 32'h44, 32'h0,        32'h0,         2, 2, 2, 2, 1'b0);
        add(3'b001, 1'b1, 1'b0, 32'h44, 32'h0,        32'h0,         2, 3, 2, 3, 1'b0);
        add(3'b001, 1'b0, 1'b0, 32'h40, 32'h0,        32'h11,        2, 3, 2, 3, 1'b0);
        add(3'b001, 1'b1, 1'b0, 32'h40, 32'h0,        32'h11,        2, 4, 2, 3, 1'b0);
        add(3'b000, 1'b0, 1'b0, 32'h00, 32'h0,        32'h11,        2, 4, 2, 3, 1'b0);
        add(3'b110, 1'b1, 1'b1, 32'h00, 32'hFF,       32'h11,        2, 4, 2, 3, 1'b0);
        add(3'b110, 1'b0, 1'b0, 32'h08, 32'h0,        32'h11,        2, 4, 2, 3, 1'b0);
        add(3'b001, 1'b0, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF,  2, 4, 2, 3, 1'b0);
        add(3'b001, 1'b1, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF,  2, 5, 2, 3, 1'b0);
        add(3'b000, 1'b0, 1'b0, 32'h00, 32'h0,        32'hDEADBEEF,  2, 5, 2, 3, 1'b0);
        add(3'b001, 1'b0, 1'b1, 32'h04, 32'h55,       32'hDEADBEEF,  2, 5, 2, 3, 1'b0);
        add(3'b001, 1'b0, 1'b1, 32'h04, 32'h55,       32'hDEADBEEF,  2, 5, 2, 3, 1'b0);
        add(3'b001, 1'b1, 1'b1, 32'h0C, 32'h55,       32'hDEADBEEF,  2, 5, 2, 3, 1'b1);
        add(3'b000, 1'b0, 1'b0, 32'h00, 32'h0,        32'hDEADBEEF,  2, 5, 2, 3, 1'b1);
        add(3'b001, 1'b0, 1'b0, 32'h04, 32'h0,        32'h0,         2, 5, 2, 3, 1'b1);
        add(3'b001, 1'b1, 1'b0, 32'h04, 32'h0,        32'h0,         2, 6, 2, 3, 1'b1);
        add(3'b001, 1'b0, 1'b0, 32'h0C, 32'h0,        32'h0,         2, 6, 2, 3, 1'b1);
        add(3'b001, 1'b1, 1'b0, 32'h0C, 32'h0,        32'h0,         2, 7, 2, 3, 1'b1);
        add(3'b000, 1'b0, 1'b0, 32'h00, 32'h0,        32'h0,         2, 7, 2, 3, 1'b1);

        foreach (vecs[i]) begin
            step(vecs[i].psel, vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            check($sformatf("row%0d prdata_a", i), prdata_a, vecs[i].prdata);
            check($sformatf("row%0d prdata_b", i), prdata_b, vecs[i].prdata);
            check($sformatf("row%0d wr_a", i), 32'(wr_a), vecs[i].wa);
            check($sformatf("row%0d rd_a", i), 32'(rd_a), vecs[i].ra);
            check($sformatf("row%0d wr_b", i), 32'(wr_b), vecs[i].wb);
            check($sformatf("row%0d rd_b", i), 32'(rd_b), vecs[i].rb);
            check($sformatf("row%0d err_a", i), 32'(err_a), 32'(vecs[i].err));
            check($sformatf("row%0d err_b", i), 32'(err_b), 32'(vecs[i].err));
        end

        // Stray enable without a setup phase must flag an error and leave memory alone.
        do_reset();
        step(3'b001, 1'b0, 1'b1, 32'h0, 32'h33);
        step(3'b001, 1'b1, 1'b1, 32'h0, 32'h33);
        step(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        check("stray err before", 32'(err_a), 32'h0);
        step(3'b001, 1'b1, 1'b1, 32'h0, 32'hAA);
        check("stray err", 32'(err_a), 32'h1);
        check("stray wr_count", 32'(wr_a), 32'h1);
        step(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        step(3'b001, 1'b0, 1'b0, 32'h0, 32'h0);
        check("stray mem intact", prdata_a, 32'h33);
        step(3'b001, 1'b1, 1'b0, 32'h0, 32'h0);
        check("stray rd_count", 32'(rd_a), 32'h1);
        check("stray wr_count after", 32'(wr_a), 32'h1);

        // Reset asserted during the enable cycle of a write.
        do_reset();
        step(3'b001, 1'b0, 1'b1, 32'h8, 32'h99);
        step(3'b001, 1'b1, 1'b1, 32'h8, 32'h99);
        step(3'b001, 1'b0, 1'b0, 32'h8, 32'h0);
        step(3'b001, 1'b1, 1'b0, 32'h8, 32'h0);
        check("pre-reset prdata", prdata_a, 32'h99);
        step(3'b001, 1'b0, 1'b1, 32'h8, 32'h77);
        @(negedge Hclk);
        apply(3'b001, 1'b1, 1'b1, 32'h8, 32'h77);
        #2 Hresetn = 1'b0;
        #1;
        check("mid-reset prdata", prdata_a, 32'h0);
        check("mid-reset wr_count", 32'(wr_a), 32'h0);
        check("mid-reset rd_count", 32'(rd_a), 32'h0);
        check("mid-reset prot_err", 32'(err_a), 32'h0);
        @(negedge Hclk);
        apply(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        Hresetn = 1'b1;
        step(3'b001, 1'b0, 1'b0, 32'h8, 32'h0);
        check("post-reset read data", prdata_a, 32'h0);
        step(3'b001, 1'b1, 1'b0, 32'h8, 32'h0);
        check("post-reset wr_count", 32'(wr_a), 32'h0);
        check("post-reset rd_count", 32'(rd_a), 32'h1);
        check("post-reset prot_err", 32'(err_a), 32'h0);

        // Select dropped between setup and enable.
        do_reset();
        step(3'b001, 1'b0, 1'b0, 32'h4, 32'h0);
        step(3'b000, 1'b0, 1'b0, 32'h4, 32'h0);
        check("setup abandon err", 32'(err_a), 32'h1);
        check("setup abandon rd_count", 32'(rd_a), 32'h0);

        // Enable held for a second cycle after the access.
        do_reset();
        step(3'b001, 1'b0, 1'b0, 32'h4, 32'h0);
        step(3'b001, 1'b1, 1'b0, 32'h4, 32'h0);
        check("access ok err", 32'(err_a), 32'h0);
        step(3'b001, 1'b1, 1'b0, 32'h4, 32'h0);
        check("double enable err", 32'(err_a), 32'h1);
        check("double enable rd_count", 32'(rd_a), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
